// File: rtl/gb_mem_responder.sv
// Memory-side target for the CPU address/rd/wr bus: decodes WRAM (with echo),
// HRAM and IE, answering reads on the third edge after the M-cycle strobe.
module gb_mem_responder #(
  parameter int WRAM_AW = 13,
  parameter int HRAM_AW = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_in,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1t1,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        abort,
  output logic        bus_err,
  output logic [7:0]  ie_reg,
  output logic [1:0]  phase
);

  // Handshake: a request (addr_bus/data_in/rd/wr) is taken on every edge
  // where m1t1=1, with no back-pressure. data_valid qualifies data_out for
  // exactly one cycle; a strobe arriving in LATCH or ACCESS kills the
  // in-flight transaction and raises abort for one cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } phase_t;

  phase_t      r_phase;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_rd;
  logic        r_wr;
  logic [7:0]  r_rdata;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_abort;
  logic        r_bus_err;
  logic [7:0]  r_ie;

  logic [7:0] wram [0:(2**WRAM_AW)-1];
  logic [7:0] hram [0:(2**HRAM_AW)-1];

  logic               w_is_wram;
  logic               w_is_echo;
  logic               w_is_ram;
  logic               w_is_hram;
  logic               w_is_ie;
  logic               w_illegal;
  logic               w_complete;
  logic               w_write;
  logic [WRAM_AW-1:0] w_widx;
  logic [HRAM_AW-1:0] w_hidx;
  logic [7:0]         w_rd_value;

  assign w_is_wram = (r_addr[15:13] == 3'b110);
  assign w_is_echo = (r_addr >= 16'hE000) && (r_addr <= 16'hFDFF);
  assign w_is_ram  = w_is_wram || w_is_echo;
  assign w_is_hram = (r_addr >= 16'hFF80) && (r_addr != 16'hFFFF);
  assign w_is_ie   = (r_addr == 16'hFFFF);
  assign w_widx    = r_addr[WRAM_AW-1:0];
  assign w_hidx    = r_addr[HRAM_AW-1:0];
  assign w_illegal = r_rd && r_wr;

  // A strobe on the ACCESS->DONE edge aborts, so completion requires !m1t1.
  assign w_complete = (r_phase == ACCESS) && !m1t1;
  assign w_write    = w_complete && r_wr && !r_rd;

  always_comb begin
    w_rd_value = 8'hFF;
    if (w_is_ie)
      w_rd_value = r_ie;
    else if (w_is_ram || w_is_hram)
      w_rd_value = r_rdata;
  end

  // Arrays have no reset so their contents survive rst.
  always_ff @(posedge clk) begin
    if (w_write && w_is_ram)
      wram[w_widx] <= r_wdata;
    if (w_write && w_is_hram)
      hram[w_hidx] <= r_wdata;
    if (r_phase == LATCH)
      r_rdata <= w_is_hram ? hram[w_hidx] : wram[w_widx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= IDLE;
      r_addr       <= 16'h0000;
      r_wdata      <= 8'h00;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_data_out   <= 8'hFF;
      r_data_valid <= 1'b0;
      r_abort      <= 1'b0;
      r_bus_err    <= 1'b0;
      r_ie         <= 8'h00;
    end else begin
      r_data_valid <= 1'b0;
      r_abort      <= 1'b0;
      r_bus_err    <= 1'b0;

      if (w_complete) begin
        if (w_illegal) begin
          r_data_out   <= 8'hFF;
          r_data_valid <= 1'b1;
          r_bus_err    <= 1'b1;
        end else if (r_rd) begin
          r_data_out   <= w_rd_value;
          r_data_valid <= 1'b1;
        end else if (r_wr && w_is_ie) begin
          r_ie <= r_wdata;
        end
      end

      if (m1t1) begin
        r_addr  <= addr_bus;
        r_wdata <= data_in;
        r_rd    <= rd;
        r_wr    <= wr;
        r_phase <= LATCH;
        // DONE has already delivered its result, so a strobe there is not an abort.
        if ((r_phase == LATCH) || (r_phase == ACCESS))
          r_abort <= 1'b1;
      end else begin
        case (r_phase)
          IDLE:    r_phase <= IDLE;
          LATCH:   r_phase <= ACCESS;
          ACCESS:  r_phase <= DONE;
          DONE:    r_phase <= IDLE;
          default: r_phase <= IDLE;
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign abort      = r_abort;
  assign bus_err    = r_bus_err;
  assign ie_reg     = r_ie;
  assign phase      = r_phase;

endmodule

// File: tb/tb_gb_mem_responder.sv
// Bench for gb_mem_responder: directed scenarios plus randomized transactions
// checked against a transaction-level memory map model.
module tb_gb_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  data_in;
  logic        rd;
  logic        wr;
  logic        m1t1;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        abort;
  logic        bus_err;
  logic [7:0]  ie_reg;
  logic [1:0]  phase;

  int n_chk;
  int n_fail;

  logic [7:0] ref_mem [int];
  logic [7:0] ref_ie;
  logic [7:0] exp_q [$];

  gb_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .addr_bus   (addr_bus),
    .data_in    (data_in),
    .rd         (rd),
    .wr         (wr),
    .m1t1       (m1t1),
    .data_out   (data_out),
    .data_valid (data_valid),
    .abort      (abort),
    .bus_err    (bus_err),
    .ie_reg     (ie_reg),
    .phase      (phase)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory map model: -1 unmapped, -2 IE, otherwise a storage key.
  function automatic int canon(input logic [15:0] a);
    if (a >= 16'hC000 && a <= 16'hFDFF) return int'(a - 16'hC000) % 8192;
    if (a == 16'hFFFF) return -2;
    if (a >= 16'hFF80) return 16'h2000 + int'(a[6:0]);
    return -1;
  endfunction

  function automatic bit known(input logic [15:0] a);
    int k = canon(a);
    return (k < 0) || ref_mem.exists(k);
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int k = canon(a);
    if (k == -1) return 8'hFF;
    if (k == -2) return ref_ie;
    return ref_mem[k];
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    int k = canon(a);
    if (k == -2) ref_ie = d;
    else if (k >= 0) ref_mem[k] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a strobe so that it is sampled at the next edge (E0); returns #1 after E0.
  task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    addr_bus = a;
    data_in  = d;
    rd       = r;
    wr       = w;
    m1t1     = 1'b1;
    step();
    m1t1 = 1'b0;
    rd   = 1'b0;
    wr   = 1'b0;
  endtask

  // Full uninterrupted transaction, checked edge by edge through E3.
  task automatic do_txn(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    logic [7:0] exp;
    bit chk_data;
    chk_data = 1'b0;
    if (r && w) begin
      exp_q.push_back(8'hFF);
      chk_data = 1'b1;
    end else if (r && known(a)) begin
      exp_q.push_back(model_read(a));
      chk_data = 1'b1;
    end
    strobe(a, d, r, w);
    check("dv_e0", data_valid, 1'b0);
    step();
    check("dv_e1", data_valid, 1'b0);
    step();
    check("dv_e2", data_valid, r);
    check("berr_e2", bus_err, r && w);
    check("abort_e2", abort, 1'b0);
    if (chk_data) begin
      exp = exp_q.pop_front();
      check("dout_e2", data_out, exp);
    end
    if (w && !r) model_write(a, d);
    step();
    check("dv_e3", data_valid, 1'b0);
    check("berr_e3", bus_err, 1'b0);
    check("phase_e3", phase, 2'd0);
    check("ie_reg", ie_reg, ref_ie);
  endtask

  logic [15:0] pool [12];

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    ref_ie   = 8'h00;
    addr_bus = 16'h0000;
    data_in  = 8'h00;
    rd       = 1'b0;
    wr       = 1'b0;
    m1t1     = 1'b0;
    rst      = 1'b1;
    #2;
    check("rst_dout", data_out, 8'hFF);
    check("rst_dv", data_valid, 1'b0);
    check("rst_abort", abort, 1'b0);
    check("rst_berr", bus_err, 1'b0);
    check("rst_ie", ie_reg, 8'h00);
    check("rst_phase", phase, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // WRAM write then read, 3-edge latency checked inside do_txn
    do_txn(16'hC123, 8'hA5, 1'b0, 1'b1);
    do_txn(16'hC123, 8'h00, 1'b1, 1'b0);

    // echo alias and unmapped reads
    do_txn(16'hC010, 8'h3C, 1'b0, 1'b1);
    do_txn(16'hE010, 8'h00, 1'b1, 1'b0);
    do_txn(16'hFE00, 8'h00, 1'b1, 1'b0);
    do_txn(16'h8000, 8'h00, 1'b1, 1'b0);
    do_txn(16'hFF00, 8'h12, 1'b0, 1'b1);
    do_txn(16'hFF00, 8'h00, 1'b1, 1'b0);

    // HRAM and IE
    do_txn(16'hFF80, 8'h77, 1'b0, 1'b1);
    do_txn(16'hFFFF, 8'h1F, 1'b0, 1'b1);
    do_txn(16'hFF80, 8'h00, 1'b1, 1'b0);
    do_txn(16'hFFFF, 8'h00, 1'b1, 1'b0);
    check("ie_1f", ie_reg, 8'h1F);

    // write aborted one edge in by a read of the same byte
    do_txn(16'hC000, 8'h00, 1'b0, 1'b1);
    addr_bus = 16'hC000; data_in = 8'h55; wr = 1'b1; rd = 1'b0; m1t1 = 1'b1;
    step();
    addr_bus = 16'hC000; wr = 1'b0; rd = 1'b1;
    step();
    m1t1 = 1'b0; rd = 1'b0;
    check("abort_pulse", abort, 1'b1);
    check("abort_dv", data_valid, 1'b0);
    step();
    check("abort_clear", abort, 1'b0);
    check("abort_dv2", data_valid, 1'b0);
    step();
    check("abort_rd_dv", data_valid, 1'b1);
    check("abort_rd_data", data_out, 8'h00);
    step();
    check("abort_rd_dv_clr", data_valid, 1'b0);
    do_txn(16'hC000, 8'h00, 1'b1, 1'b0);

    // read aborted in ACCESS by a read of IE
    strobe(16'hFF80, 8'h00, 1'b1, 1'b0);
    step();
    addr_bus = 16'hFFFF; rd = 1'b1; m1t1 = 1'b1;
    step();
    m1t1 = 1'b0; rd = 1'b0;
    check("abort2_pulse", abort, 1'b1);
    check("abort2_dv", data_valid, 1'b0);
    step();
    check("abort2_dv1", data_valid, 1'b0);
    step();
    check("abort2_dv", data_valid, 1'b1);
    check("abort2_data", data_out, ref_ie);
    step();

    // back-to-back: strobe on the DONE edge is not an abort
    strobe(16'hC123, 8'h00, 1'b1, 1'b0);
    step();
    step();
    check("b2b_dv1", data_valid, 1'b1);
    check("b2b_d1", data_out, 8'hA5);
    addr_bus = 16'hE010; rd = 1'b1; m1t1 = 1'b1;
    step();
    m1t1 = 1'b0; rd = 1'b0;
    check("b2b_abort", abort, 1'b0);
    check("b2b_dv_clr", data_valid, 1'b0);
    step();
    step();
    check("b2b_dv2", data_valid, 1'b1);
    check("b2b_d2", data_out, 8'h3C);
    step();

    // illegal rd+wr leaves memory alone
    do_txn(16'hC000, 8'h99, 1'b1, 1'b1);
    do_txn(16'hC000, 8'h00, 1'b1, 1'b0);

    // reset during ACCESS of a write
    strobe(16'hC123, 8'hEE, 1'b0, 1'b1);
    step();
    check("pre_rst_phase", phase, 2'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_phase", phase, 2'd0);
    check("mid_rst_dout", data_out, 8'hFF);
    check("mid_rst_ie", ie_reg, 8'h00);
    check("mid_rst_dv", data_valid, 1'b0);
    ref_ie = 8'h00;
    step();
    step();
    rst = 1'b0;
    do_txn(16'hC123, 8'h00, 1'b1, 1'b0);
    do_txn(16'hFFFF, 8'h00, 1'b1, 1'b0);
    do_txn(16'hFF80, 8'h00, 1'b1, 1'b0);

    // randomized traffic across regions and aliases
    pool = '{16'hC005, 16'hE005, 16'hDDFF, 16'hFDFF, 16'hDE00, 16'hFE00,
             16'hFF7F, 16'hFF80, 16'hFFFE, 16'hFFFF, 16'h8000, 16'h0000};
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      int op;
      a  = pool[$urandom_range(11, 0)];
      d  = 8'($urandom_range(255, 0));
      op = $urandom_range(9, 0);
      if (op < 4)      do_txn(a, d, 1'b0, 1'b1);
      else if (op < 8) do_txn(a, d, 1'b1, 1'b0);
      else if (op < 9) do_txn(a, d, 1'b1, 1'b1);
      else             do_txn(a, d, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
